complex_alu_seq: RTL and testbench

Parametrised sequential complex-number ALU for the datapath. It accepts two complex operands (a+bi) and (c+di) with a 2-bit opcode through a valid/ready input handshake. Add and subtract complete in one execute cycle; multiply and conjugate-multiply time-share one signed multiplier over four cycles. Results are held on a valid/ready output handshake until the consumer takes them.

---
 rtl/complex_alu_seq.sv | 154 +++++++++++++++
 tb/tb_complex_alu_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/complex_alu_seq.sv
// complex_alu_seq: sequential complex-number ALU.
// Computes (a+bi) op (c+di) for add, sub, mul and conjugate-mul (a+bi)(c-di).
// Add/sub take one execute cycle. Mul/conj time-share one signed WxW multiplier
// over four cycles. Results are held until the consumer takes them.
//
// Ports:
//   clk                  rising-edge clock
//   rst                  asynchronous active-high reset
//   in_valid / in_ready  operand handshake (in_ready high only in IDLE)
//   opcode               00 add, 01 sub, 10 mul, 11 conj-mul
//   a, b, c, d           signed operands: op1 = a+bi, op2 = c+di
//   out_valid/out_ready  result handshake
//   result_r, result_i   signed real / imaginary result, RW = 2W+1 bits
module complex_alu_seq #(
  parameter  int unsigned W  = 4,
  localparam int unsigned RW = 2*W + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           opcode,
  input  logic signed [W-1:0]  a,
  input  logic signed [W-1:0]  b,
  input  logic signed [W-1:0]  c,
  input  logic signed [W-1:0]  d,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [RW-1:0] result_r,
  output logic signed [RW-1:0] result_i
);

  localparam int unsigned PW = 2*W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADDSUB = 2'd1,
    S_MUL    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t               state;
  logic [1:0]           step;
  logic [1:0]           op_q;
  logic signed [W-1:0]  a_q, b_q, c_q, d_q;
  logic signed [RW-1:0] acc_r, acc_i;

  logic signed [W-1:0]  mul_x_c, mul_y_c;
  logic signed [PW-1:0] prod_c;
  logic signed [RW-1:0] prod_ext_c;
  logic signed [RW-1:0] acc_base_c, acc_next_c;
  logic                 acc_sub_c;
  logic signed [RW-1:0] a_ext_c, b_ext_c, c_ext_c, d_ext_c;
  logic signed [RW-1:0] addsub_r_c, addsub_i_c;

  // Ready is a pure state decode, so there is no path from in_valid.
  assign in_ready = (state == S_IDLE);

  // Operand select for the shared multiplier: ac, bd, bc, ad.
  always_comb begin
    mul_x_c = a_q;
    mul_y_c = c_q;
    case (step)
      2'd0: begin mul_x_c = a_q; mul_y_c = c_q; end
      2'd1: begin mul_x_c = b_q; mul_y_c = d_q; end
      2'd2: begin mul_x_c = b_q; mul_y_c = c_q; end
      2'd3: begin mul_x_c = a_q; mul_y_c = d_q; end
      default: begin mul_x_c = a_q; mul_y_c = c_q; end
    endcase
  end

  assign prod_c     = PW'(mul_x_c) * PW'(mul_y_c);
  assign prod_ext_c = RW'(prod_c);

  // Step1 subtracts for mul, adds for conj; step3 is the opposite.
  assign acc_sub_c  = (step == 2'd1) ? ~op_q[0] : op_q[0];
  assign acc_base_c = step[1] ? acc_i : acc_r;
  assign acc_next_c = acc_sub_c ? (acc_base_c - prod_ext_c) : (acc_base_c + prod_ext_c);

  // Sign-extended add/sub datapath.
  assign a_ext_c    = RW'(a_q);
  assign b_ext_c    = RW'(b_q);
  assign c_ext_c    = RW'(c_q);
  assign d_ext_c    = RW'(d_q);
  assign addsub_r_c = op_q[0] ? (a_ext_c - c_ext_c) : (a_ext_c + c_ext_c);
  assign addsub_i_c = op_q[0] ? (b_ext_c - d_ext_c) : (b_ext_c + d_ext_c);

  // Control FSM with registered datapath and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      step      <= 2'd0;
      op_q      <= 2'd0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      acc_r     <= '0;
      acc_i     <= '0;
      result_r  <= '0;
      result_i  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q  <= opcode;
            a_q   <= a;
            b_q   <= b;
            c_q   <= c;
            d_q   <= d;
            step  <= 2'd0;
            state <= opcode[1] ? S_MUL : S_ADDSUB;
          end
        end
        S_ADDSUB: begin
          result_r  <= addsub_r_c;
          result_i  <= addsub_i_c;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_MUL: begin
          step <= step + 2'd1;
          case (step)
            2'd0: acc_r <= prod_ext_c;
            2'd1: begin
              acc_r    <= acc_next_c;
              result_r <= acc_next_c;
            end
            2'd2: acc_i <= prod_ext_c;
            2'd3: begin
              acc_i     <= acc_next_c;
              result_i  <= acc_next_c;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
            default: step <= 2'd0;
          endcase
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_complex_alu_seq.sv
// tb_complex_alu_seq: table-driven, scoreboard-checked bench for complex_alu_seq.
module tb_complex_alu_seq;

  localparam int unsigned W  = 4;
  localparam int unsigned RW = 2*W + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           opcode;
  logic signed [W-1:0]  a, b, c, d;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [RW-1:0] result_r, result_i;

  complex_alu_seq #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result_r  (result_r),
    .result_i  (result_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    int a, b, c, d;
    int er, ei;
    int hold;
  } vec_t;

  typedef struct {
    int r;
    int i;
    int lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model in plain integer arithmetic.
  function automatic void model(input logic [1:0] op, input int xa, input int xb,
                                input int xc, input int xd, output int r, output int i);
    case (op)
      2'b00: begin r = xa + xc;           i = xb + xd;           end
      2'b01: begin r = xa - xc;           i = xb - xd;           end
      2'b10: begin r = xa*xc - xb*xd;     i = xb*xc + xa*xd;     end
      default: begin r = xa*xc + xb*xd;   i = xb*xc - xa*xd;     end
    endcase
  endfunction

  // Drive one op, push expectation, check latency, backpressure and handshake.
  task automatic run_op(input vec_t v);
    exp_t e;
    int   n;
    int   lat;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("in_ready_before_accept", int'(in_ready), 1);
    opcode   = v.op;
    a        = W'(v.a);
    b        = W'(v.b);
    c        = W'(v.c);
    d        = W'(v.d);
    in_valid = 1'b1;
    sb.push_back('{r: v.er, i: v.ei, lat: (v.op[1] ? 4 : 1)});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("in_ready_low_after_accept", int'(in_ready), 0);
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("latency", lat, e.lat);
    for (int k = 0; k < v.hold; k++) begin
      in_valid = 1'($urandom_range(1));
      opcode   = 2'($urandom_range(3));
      a        = W'($urandom_range(15));
      b        = W'($urandom_range(15));
      c        = W'($urandom_range(15));
      d        = W'($urandom_range(15));
      @(posedge clk); #1;
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_result_r", int'(result_r), e.r);
      chk("hold_result_i", int'(result_i), e.i);
    end
    in_valid = 1'b0;
    chk("result_r", int'(result_r), e.r);
    chk("result_i", int'(result_i), e.i);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_handshake", int'(out_valid), 0);
    chk("in_ready_after_handshake", int'(in_ready), 1);
    chk("result_r_kept", int'(result_r), e.r);
  endtask

  initial begin
    vec_t v;
    int   hs;
    int   er, ei;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; opcode = 2'b00;
    a = '0; b = '0; c = '0; d = '0;

    vecs[0] = '{op: 2'b00, a:  3, b: -2, c:  5, d:  7, er:   8, ei:   5, hold: 0};
    vecs[1] = '{op: 2'b01, a: -8, b:  7, c:  7, d: -8, er: -15, ei:  15, hold: 0};
    vecs[2] = '{op: 2'b10, a:  3, b:  2, c:  1, d:  4, er:  -5, ei:  14, hold: 0};
    vecs[3] = '{op: 2'b11, a:  3, b:  2, c:  1, d:  4, er:  11, ei: -10, hold: 0};
    vecs[4] = '{op: 2'b11, a: -8, b: -8, c: -8, d: -8, er: 128, ei:   0, hold: 0};
    vecs[5] = '{op: 2'b10, a: -8, b: -8, c: -8, d:  7, er: 120, ei:   8, hold: 10};
    for (int k = 6; k < 10; k++) begin
      vecs[k].op   = 2'($urandom_range(3));
      vecs[k].a    = int'($urandom_range(15)) - 8;
      vecs[k].b    = int'($urandom_range(15)) - 8;
      vecs[k].c    = int'($urandom_range(15)) - 8;
      vecs[k].d    = int'($urandom_range(15)) - 8;
      model(vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].c, vecs[k].d, er, ei);
      vecs[k].er   = er;
      vecs[k].ei   = ei;
      vecs[k].hold = 2;
    end

    #12;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_result_r", int'(result_r), 0);
    chk("reset_result_i", int'(result_i), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 10; k++) run_op(vecs[k]);

    // out_ready held high early: DONE still lasts a cycle, results correct.
    out_ready = 1'b1;
    opcode = 2'b00; a = 4'sd1; b = 4'sd2; c = 4'sd3; d = -4'sd4;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("early_ready_out_valid", int'(out_valid), 1);
    chk("early_ready_result_r", int'(result_r), 4);
    chk("early_ready_result_i", int'(result_i), -2);
    @(posedge clk); #1;
    chk("early_ready_released", int'(out_valid), 0);

    // Continuous in_valid with out_ready high: one add per 3 cycles.
    @(negedge clk);
    opcode = 2'b00; a = 4'sd2; b = -4'sd3; c = 4'sd1; d = 4'sd1;
    in_valid = 1'b1;
    hs = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        hs++;
        chk("stream_result_r", int'(result_r), 3);
        chk("stream_result_i", int'(result_i), -2);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("stream_handshakes", hs, 10);
    @(posedge clk); #1;

    // Reset asserted while MUL is about to execute step2.
    v = '{op: 2'b10, a: 3, b: 2, c: 1, d: 4, er: -5, ei: 14, hold: 0};
    opcode = v.op; a = W'(v.a); b = W'(v.b); c = W'(v.c); d = W'(v.d);
    chk("pre_reset_in_ready", int'(in_ready), 1);
    in_valid = 1'b1;
    sb.push_back('{r: v.er, i: v.ei, lat: 4});
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    sb.delete();
    chk("midop_reset_in_ready", int'(in_ready), 1);
    chk("midop_reset_out_valid", int'(out_valid), 0);
    chk("midop_reset_result_r", int'(result_r), 0);
    chk("midop_reset_result_i", int'(result_i), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("post_reset_no_valid", int'(out_valid), 0);
    end
    run_op('{op: 2'b00, a: 1, b: 1, c: 1, d: 1, er: 2, ei: 2, hold: 0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
